mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the busy cycles allowed before a transaction is aborted; 0 disables the timeout.
REQ-002 Parameter MAX_DM_STREAK, default 4, SHALL set the consecutive data grants allowed while fetch waits.
REQ-003 CK_REF  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 RST  in  1  SHALL be the synchronous, active-high reset.
REQ-005 IF_REQ  in  1  instruction-fetch request, held until IF_ACK.
REQ-006 IF_ADDR  in  32  fetch address, stable while IF_REQ is high.
REQ-007 IF_ACK  out  1  one-cycle completion pulse to fetch.
REQ-008 IF_RDATA  out  32  fetched word, valid while IF_ACK is high.
REQ-009 DM_REQ  in  1  data-access request, held until DM_ACK.
REQ-010 DM_READ_WRN  in  1  1 = load, 0 = store.
REQ-011 DM_ADDR  in  16  data address, zero-extended onto MEM_ADDR.
REQ-012 DM_WDATA  in  32  store data.
REQ-013 DM_ACK  out  1  one-cycle completion pulse to data stage.
REQ-014 DM_RDATA  out  32  load word, valid while DM_ACK is high.
REQ-015 MEM_REQ / MEM_READ_WRN / MEM_ADDR[31:0] / MEM_WDATA[31:0]  out  single shared memory port, all registered.
REQ-016 MEM_ACK  in  1 / MEM_RDATA  in  32  memory completion strobe and read data.
REQ-017 HALT  out  1  pipeline stall request.
REQ-018 ERR  out  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have the states IDLE, IF_BUSY and DM_BUSY.
REQ-020 In IDLE, when any request is eligible, the block SHALL latch the winner's address, direction and data, move to the matching BUSY state, and drive MEM_REQ=1 from the next cycle.
REQ-021 Arbitration SHALL give data priority over fetch, except that fetch SHALL win once the streak counter equals MAX_DM_STREAK.
REQ-022 The streak counter SHALL increment on each data grant made while IF_REQ is high, and SHALL clear on every fetch grant or whenever IF_REQ is low.
REQ-023 In a BUSY state, MEM_REQ and the latched port fields SHALL stay stable until MEM_ACK=1 is sampled.
REQ-024 On sampling MEM_ACK, the block SHALL deassert MEM_REQ and return to IDLE.
REQ-025 In the cycle after MEM_ACK, the owner's ACK SHALL pulse with RDATA = MEM_RDATA registered; stores return RDATA = 0.
REQ-026 Transaction latency SHALL be request sampled -> MEM_REQ +1 cycle, and MEM_ACK -> requester ACK +1 cycle.
REQ-027 A requester whose ACK is high in the current cycle SHALL be ineligible for arbitration in that cycle.
REQ-028 MEM_ACK sampled in IDLE SHALL be ignored and SHALL have no effect.
REQ-029 A busy counter SHALL reset on entry to a BUSY state; if it reaches TIMEOUT_CYCLES with no MEM_ACK (TIMEOUT_CYCLES non-zero), the block SHALL drop MEM_REQ, pulse the owner's ACK with RDATA = 32'hDEAD_BEEF, set ERR, and return to IDLE.
REQ-030 The busy counter SHALL saturate and never wrap.
REQ-031 HALT SHALL be combinational: (IF_REQ & ~IF_ACK) | (DM_REQ & ~DM_ACK).
REQ-032 HALT SHALL be forced to 0 while RST is high.
REQ-033 When requests are simultaneous in IDLE, exactly one grant SHALL be issued per cycle, and the loser SHALL remain pending.

Reset
REQ-034 While RST is high at a clock edge, state SHALL become IDLE, and all registered outputs, the streak counter, the busy counter and ERR SHALL be 0.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction with no ACK issued; MEM_REQ SHALL be 0 in the first cycle after that edge.
REQ-036 ERR SHALL clear only on reset.

Structure
REQ-037 The FSM state encodings, the DEAD_BEEF error constant and the default parameter values SHALL live in the shared defines file.
REQ-038 The block SHALL be a single module with no sub-modules.
REQ-039 The intended size SHALL be 150-250 lines of RTL.

Verification
REQ-040 Single load: DM_REQ with addr 0x0040, memory acks after 3 cycles with 0x1234_5678 -> MEM_REQ high for 3 cycles; DM_ACK pulses once with DM_RDATA=0x1234_5678; HALT falls in the same cycle as DM_ACK.
REQ-041 Simultaneous IF_REQ (0x100) and DM_REQ (store 0xCAFE_0001) -> the data access is granted first, then the fetch with MEM_ADDR=0x100; each ACK pulses exactly once.
REQ-042 Starvation: with MAX_DM_STREAK=4, DM_REQ continuously re-asserted and IF_REQ held -> the fetch is granted as the 5th transaction.
REQ-043 Timeout: with TIMEOUT_CYCLES=8 and no MEM_ACK -> MEM_REQ drops after 8 busy cycles; the owner's ACK pulses with 0xDEAD_BEEF; ERR=1 and stays set until RST.
REQ-044 Reset mid-transaction: RST asserted 2 cycles into DM_BUSY -> no ACK is issued; all outputs are 0; a subsequent request completes normally.
REQ-045 A spurious MEM_ACK in IDLE -> no ACK pulse and no state change.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_DM_BUSY = 2'd2
    } state_e;

    localparam logic [31:0] ERR_RDATA          = 32'hDEAD_BEEF;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam int unsigned DEF_MAX_DM_STREAK  = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one registered memory port between instruction fetch and data access,
// with data priority, bounded fetch starvation and a transaction timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned MAX_DM_STREAK  = DEF_MAX_DM_STREAK
) (
    input  logic        CK_REF,
    input  logic        RST,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic        IF_ACK,
    output logic [31:0] IF_RDATA,
    input  logic        DM_REQ,
    input  logic        DM_READ_WRN,
    input  logic [15:0] DM_ADDR,
    input  logic [31:0] DM_WDATA,
    output logic        DM_ACK,
    output logic [31:0] DM_RDATA,
    output logic        MEM_REQ,
    output logic        MEM_READ_WRN,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    output logic        HALT,
    output logic        ERR
);

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_read_wrn_q, mem_read_wrn_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        if_ack_q, if_ack_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        dm_ack_q, dm_ack_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic [31:0] streak_q, streak_d;
    logic [31:0] busy_cnt_q, busy_cnt_d;
    logic        err_q, err_d;

    logic if_elig, dm_elig, grant_if, grant_dm, done, timed_out;
    logic [31:0] done_rdata;

    always_comb begin
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_read_wrn_d = mem_read_wrn_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        if_ack_d       = 1'b0;
        if_rdata_d     = '0;
        dm_ack_d       = 1'b0;
        dm_rdata_d     = '0;
        streak_d       = streak_q;
        busy_cnt_d     = busy_cnt_q;
        err_d          = err_q;
        done           = 1'b0;
        done_rdata     = '0;

        // No grant while an ACK is out: the acked side is ineligible, and
        // holding the other side one cycle lets a requester that re-asserts
        // straight after its ACK compete under the streak rule.
        if_elig   = IF_REQ && !if_ack_q && !dm_ack_q;
        dm_elig   = DM_REQ && !dm_ack_q && !if_ack_q;
        grant_if  = if_elig && (!dm_elig || streak_q == MAX_DM_STREAK);
        grant_dm  = dm_elig && !grant_if;
        timed_out = (TIMEOUT_CYCLES != 0) && (busy_cnt_q + 32'd1 == TIMEOUT_CYCLES);

        case (state_q)
            ST_IDLE: begin
                if (grant_if) begin
                    state_d        = ST_IF_BUSY;
                    mem_req_d      = 1'b1;
                    mem_read_wrn_d = 1'b1;
                    mem_addr_d     = IF_ADDR;
                    mem_wdata_d    = '0;
                    busy_cnt_d     = '0;
                    streak_d       = '0;
                end else if (grant_dm) begin
                    state_d        = ST_DM_BUSY;
                    mem_req_d      = 1'b1;
                    mem_read_wrn_d = DM_READ_WRN;
                    mem_addr_d     = {16'h0000, DM_ADDR};
                    mem_wdata_d    = DM_WDATA;
                    busy_cnt_d     = '0;
                    if (IF_REQ && streak_q != MAX_DM_STREAK)
                        streak_d = streak_q + 32'd1;
                end
            end
            ST_IF_BUSY, ST_DM_BUSY: begin
                if (MEM_ACK) begin
                    done       = 1'b1;
                    done_rdata = mem_read_wrn_q ? MEM_RDATA : 32'h0;
                end else if (timed_out) begin
                    done       = 1'b1;
                    done_rdata = ERR_RDATA;
                    err_d      = 1'b1;
                end else if (busy_cnt_q != '1) begin
                    busy_cnt_d = busy_cnt_q + 32'd1;
                end
                if (done) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    if (state_q == ST_IF_BUSY) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = done_rdata;
                    end else begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = done_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!IF_REQ)
            streak_d = '0;
    end

    always_ff @(posedge CK_REF) begin
        if (RST) begin
            state_q        <= ST_IDLE;
            mem_req_q      <= 1'b0;
            mem_read_wrn_q <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            if_ack_q       <= 1'b0;
            if_rdata_q     <= '0;
            dm_ack_q       <= 1'b0;
            dm_rdata_q     <= '0;
            streak_q       <= '0;
            busy_cnt_q     <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_read_wrn_q <= mem_read_wrn_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            if_ack_q       <= if_ack_d;
            if_rdata_q     <= if_rdata_d;
            dm_ack_q       <= dm_ack_d;
            dm_rdata_q     <= dm_rdata_d;
            streak_q       <= streak_d;
            busy_cnt_q     <= busy_cnt_d;
            err_q          <= err_d;
        end
    end

    assign MEM_REQ      = mem_req_q;
    assign MEM_READ_WRN = mem_read_wrn_q;
    assign MEM_ADDR     = mem_addr_q;
    assign MEM_WDATA    = mem_wdata_q;
    assign IF_ACK       = if_ack_q;
    assign IF_RDATA     = if_rdata_q;
    assign DM_ACK       = dm_ack_q;
    assign DM_RDATA     = dm_rdata_q;
    assign ERR          = err_q;
    assign HALT         = !RST && ((IF_REQ && !if_ack_q) || (DM_REQ && !dm_ack_q));

endmodule
